// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: data width, bubble encoding, major opcodes and fetch FSM states.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0,x0,0
    localparam logic [XLEN-1:0] RV_NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Priority: reset > bubble > hold > load.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = RV_NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            hold,
    input  logic            bubble,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] pc_plus4,
    input  logic [XLEN-1:0] instr,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4,
    output logic [XLEN-1:0] id_instr
);

    always_ff @(posedge clk) begin
        if (reset) begin
            id_valid    <= 1'b0;
            id_pc       <= '0;
            id_pc_plus4 <= '0;
            id_instr    <= NOP_INSTR;
        end else if (bubble) begin
            // PC fields keep their last value; only the instruction is squashed.
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
        end else if (!hold) begin
            id_valid    <= 1'b1;
            id_pc       <= pc;
            id_pc_plus4 <= pc_plus4;
            id_instr    <= instr;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, fetch FSM (BOOT/RUN/WAIT) and IF/ID register.
// Optional performance counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = RV_NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_if,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_ready,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4,
    output logic [XLEN-1:0] id_instr
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_flush_cnt
`endif
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] redirect_target;
    logic            active;
    logic            do_redirect;
    logic            do_stall;
    logic            do_wait;
    logic            do_advance;
    logic            ifid_hold;
    logic            ifid_bubble;

    assign imem_addr       = pc;
    assign pc_plus4        = pc + 32'd4;
    assign redirect_target = redirect_pc & ~32'h3;

    always_comb begin
        active      = (state != BOOT);
        do_redirect = active && redirect_valid;
        do_stall    = active && !redirect_valid && stall_if;
        do_wait     = active && !redirect_valid && !stall_if && !imem_ready;
        do_advance  = active && !redirect_valid && !stall_if && imem_ready;
        ifid_hold   = !active || do_stall;
        ifid_bubble = do_redirect || do_wait;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BOOT;
            pc    <= RESET_PC;
        end else begin
            case (state)
                BOOT:    state <= RUN;
                RUN:     if (do_wait) state <= WAIT;
                WAIT:    if (imem_ready || redirect_valid) state <= RUN;
                default: state <= BOOT;
            endcase
            if (do_redirect)
                pc <= redirect_target;
            else if (do_advance)
                pc <= pc_plus4;
        end
    end

    if_id_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id_reg (
        .clk        (clk),
        .reset      (reset),
        .hold       (ifid_hold),
        .bubble     (ifid_bubble),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .instr      (imem_rdata),
        .id_valid   (id_valid),
        .id_pc      (id_pc),
        .id_pc_plus4(id_pc_plus4),
        .id_instr   (id_instr)
    );

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (do_advance)           perf_fetch_cnt <= sat_inc(perf_fetch_cnt);
            if (do_stall || do_wait)  perf_stall_cnt <= sat_inc(perf_stall_cnt);
            if (do_redirect)          perf_flush_cnt <= sat_inc(perf_flush_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed + short random bench for fetch_stage with a per-cycle expectation queue.
module tb_fetch_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset, stall_if, redirect_valid, imem_ready;
    logic [31:0] redirect_pc, imem_addr, imem_rdata;
    logic        id_valid;
    logic [31:0] id_pc, id_pc_plus4, id_instr;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0]  pc;
        logic         valid;
        logic [31:0]  id_pc;
        logic [31:0]  id_pc4;
        logic [31:0]  instr;
        fetch_state_t st;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    fetch_state_t m_state = BOOT;
    logic [31:0]  m_pc = '0, m_id_pc = '0, m_id_pc4 = '0, m_instr = 32'h13;
    logic         m_valid = 1'b0;

    function automatic logic [31:0] instr_at(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : ((a << 8) ^ 32'hA5A0_0000) | 32'h0000_0013;
    endfunction

    assign imem_rdata = instr_at(imem_addr);

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0013)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall_if      (stall_if),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_ready    (imem_ready),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_pc_plus4   (id_pc_plus4),
        .id_instr      (id_instr)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Advance the model one clock from the currently driven inputs, queue the
    // expectation, clock the DUT and compare.
    task automatic cycle();
        exp_t e, g;
        fetch_state_t nxt;
        nxt = m_state;
        if (reset) begin
            nxt = BOOT; m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h13;
            m_id_pc = '0; m_id_pc4 = '0;
        end else if (m_state == BOOT) begin
            nxt = RUN;
        end else begin
            if (m_state == RUN && !imem_ready && !redirect_valid && !stall_if) nxt = WAIT;
            if (m_state == WAIT && (imem_ready || redirect_valid)) nxt = RUN;
            if (redirect_valid) begin
                m_pc = {redirect_pc[31:2], 2'b00}; m_valid = 1'b0; m_instr = 32'h13;
            end else if (stall_if) begin
                // everything holds
            end else if (!imem_ready) begin
                m_valid = 1'b0; m_instr = 32'h13;
            end else begin
                m_id_pc = m_pc; m_id_pc4 = m_pc + 32'd4; m_instr = instr_at(m_pc);
                m_valid = 1'b1; m_pc = m_pc + 32'd4;
            end
        end
        m_state = nxt;
        e.pc = m_pc; e.valid = m_valid; e.id_pc = m_id_pc; e.id_pc4 = m_id_pc4;
        e.instr = m_instr; e.st = m_state;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        g = exp_q.pop_front();
        chk("imem_addr", imem_addr, g.pc);
        chk("id_valid", {31'b0, id_valid}, {31'b0, g.valid});
        chk("id_instr", id_instr, g.instr);
        chk("state", {30'b0, dut.state}, {30'b0, g.st});
        if (g.valid) begin
            chk("id_pc", id_pc, g.id_pc);
            chk("id_pc_plus4", id_pc_plus4, g.id_pc4);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; stall_if = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_ready = 1'b1;

        // 1: reset, BOOT, first capture
        cycle();
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", id_instr, 32'h13);
        reset = 1'b0;
        cycle();
        chk("boot_no_capture", {31'b0, id_valid}, 32'h0);
        cycle();
        chk("first_instr", id_instr, 32'h0050_0093);
        chk("first_pc", id_pc, 32'h0);
        chk("next_pc", imem_addr, 32'h4);
        cycle();

        // 2: stall for 3 cycles at pc 0x8
        chk("pre_stall_pc", imem_addr, 32'h8);
        stall_if = 1'b1;
        repeat (3) cycle();
        chk("stall_pc", imem_addr, 32'h8);
        chk("stall_id_pc", id_pc, 32'h4);
        stall_if = 1'b0;
        cycle();
        chk("resume_pc", imem_addr, 32'hC);
        chk("resume_id_pc", id_pc, 32'h8);

        // 3: redirect beats stall, target aligned
        stall_if = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h103;
        cycle();
        chk("redir_pc", imem_addr, 32'h100);
        chk("redir_instr", id_instr, 32'h13);
        chk("redir_valid", {31'b0, id_valid}, 32'h0);
        stall_if = 1'b0; redirect_pc = 32'h20;
        cycle();
        redirect_valid = 1'b0;

        // 4: two wait cycles at pc 0x20
        imem_ready = 1'b0;
        repeat (2) cycle();
        chk("wait_pc", imem_addr, 32'h20);
        chk("wait_state", {30'b0, dut.state}, {30'b0, WAIT});
        imem_ready = 1'b1;
        cycle();
        chk("wait_capture_pc", id_pc, 32'h20);
        chk("wait_capture_instr", id_instr, instr_at(32'h20));

        // 5: wrap-around
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        chk("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", id_pc_plus4, 32'h0);
        chk("wrap_next_pc", imem_addr, 32'h0);

        // 6: reset during WAIT with redirect pending
        imem_ready = 1'b0;
        cycle();
        cycle();
        reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h400;
        cycle();
        chk("rst_wait_pc", imem_addr, 32'h0);
        chk("rst_wait_state", {30'b0, dut.state}, {30'b0, BOOT});
        reset = 1'b0; redirect_valid = 1'b0; imem_ready = 1'b1;
        cycle();
        cycle();

        // Random mix of stalls, waits and redirects
        for (int i = 0; i < 40; i++) begin
            stall_if       = ($urandom_range(0, 3) == 0);
            imem_ready     = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 7) == 0);
            redirect_pc    = $urandom;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
